// File: rtl/afedorowicz14_pkg.sv
// Shared types and constants for the afedorowicz14 accumulator ALU.
// Flag indices refer to positions inside the 4-bit {Z,C,N,V} flag vector.
package afedorowicz14_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LOAD = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOT  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_ROL  = 4'hA,
    OP_ROR  = 4'hB,
    OP_INC  = 4'hC,
    OP_DEC  = 4'hD,
    OP_CMP  = 4'hE,
    OP_CLR  = 4'hF
  } alu_op_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/afedorowicz14_if.sv
// Pin bundle of the Tiny Tapeout user project: enable, operand/opcode inputs
// and the accumulator/flag outputs. The core is the slave side.
interface afedorowicz14_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/afedorowicz14_alu.sv
// Purely combinational 8-bit ALU: computes the result, the accumulator
// write-enable and the {Z,C,N,V} flags for one opcode.
module afedorowicz14_alu
  import afedorowicz14_pkg::*;
(
  input  logic [7:0] acc,
  input  logic [7:0] b,
  input  alu_op_t    op,
  output logic [7:0] r,
  output logic       acc_we,
  output logic [3:0] flags
);

  logic [8:0] sum;
  logic [8:0] diff;
  logic       carry;
  logic       ovf;

  assign sum  = {1'b0, acc} + {1'b0, b};
  assign diff = {1'b0, acc} - {1'b0, b};

  always_comb begin
    r      = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    acc_we = 1'b1;
    case (op)
      OP_LOAD: r = b;
      OP_ADD: begin
        r     = sum[7:0];
        carry = sum[8];
        ovf   = (acc[7] == b[7]) && (sum[7] != acc[7]);
      end
      OP_SUB, OP_CMP: begin
        // CMP shares the subtractor but leaves the accumulator untouched
        r      = diff[7:0];
        carry  = diff[8];
        ovf    = (acc[7] != b[7]) && (diff[7] != acc[7]);
        acc_we = (op == OP_SUB);
      end
      OP_AND: r = acc & b;
      OP_OR:  r = acc | b;
      OP_XOR: r = acc ^ b;
      OP_NOT: r = ~acc;
      OP_SHL: begin
        r     = {acc[6:0], 1'b0};
        carry = acc[7];
      end
      OP_SHR: begin
        r     = {1'b0, acc[7:1]};
        carry = acc[0];
      end
      OP_ROL: begin
        r     = {acc[6:0], acc[7]};
        carry = acc[7];
      end
      OP_ROR: begin
        r     = {acc[0], acc[7:1]};
        carry = acc[0];
      end
      OP_INC: begin
        r     = acc + 8'd1;
        carry = (acc == 8'hFF);
        ovf   = (acc == 8'h7F);
      end
      OP_DEC: begin
        r     = acc - 8'd1;
        carry = (acc == 8'h00);
        ovf   = (acc == 8'h80);
      end
      OP_CLR: r = '0;
      default: acc_we = 1'b0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (r == 8'h00);
    flags[FLAG_C] = carry;
    flags[FLAG_N] = r[7];
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/tt_um_afedorowicz14_core.sv
// Registered accumulator core: holds ACC and flags, runs one ALU operation
// per enabled cycle and maps state onto the Tiny Tapeout pins.
module tt_um_afedorowicz14_core
  import afedorowicz14_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  afedorowicz14_if.slave bus
);

  logic [7:0] acc;
  logic [3:0] flags;
  logic [7:0] alu_r;
  logic       alu_acc_we;
  logic [3:0] alu_flags;
  alu_op_t    op;
  logic       unused_opcode_hi;

  assign op               = alu_op_t'(bus.uio_in[3:0]);
  assign unused_opcode_hi = ^bus.uio_in[7:4];

  afedorowicz14_alu u_alu (
    .acc    (acc),
    .b      (bus.ui_in),
    .op     (op),
    .r      (alu_r),
    .acc_we (alu_acc_we),
    .flags  (alu_flags)
  );

  // Reset wins over enable; NOP is the only opcode that leaves the flags alone
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      flags <= '0;
    end else if (bus.ena) begin
      if (alu_acc_we)
        acc <= alu_r;
      if (op != OP_NOP)
        flags <= alu_flags;
    end
  end

  assign bus.uo_out  = acc;
  assign bus.uio_out = {flags, 4'b0000};
  assign bus.uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_afedorowicz14_core.sv
// Directed bench for the accumulator core: a per-cycle vector table with
// hand-computed ACC/flag values, then enable-hold and reset-mid-stream runs.
module tb_tt_um_afedorowicz14_core;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  afedorowicz14_if bus ();

  tt_um_afedorowicz14_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       ena;
    logic [7:0] uio;
    logic [7:0] b;
    logic [7:0] exp_acc;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t vecs[27];

  task automatic applyStimulus(input logic r, input logic e,
                               input logic [7:0] uio, input logic [7:0] b);
    rst        = r;
    bus.ena    = e;
    bus.uio_in = uio;
    bus.ui_in  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_acc,
                             input logic [7:0] exp_uio);
    checks++;
    if (bus.uo_out !== exp_acc)
      $display("[TB] FAIL %s uo_out: got %02h expected %02h", name, bus.uo_out, exp_acc);
    else
      passes++;
    checks++;
    if (bus.uio_out !== exp_uio)
      $display("[TB] FAIL %s uio_out: got %02h expected %02h", name, bus.uio_out, exp_uio);
    else
      passes++;
    checks++;
    if (bus.uio_oe !== 8'hF0)
      $display("[TB] FAIL %s uio_oe: got %02h expected f0", name, bus.uio_oe);
    else
      passes++;
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    rst        = 1'b1;
    bus.ena    = 1'b0;
    bus.ui_in  = '0;
    bus.uio_in = '0;

    // uio_out is {Z,C,N,V,4'b0}
    vecs[0]  = '{"rst0",     1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{"rst1",     1'b1, 1'b1, 8'h02, 8'h77, 8'h00, 8'h00};
    vecs[2]  = '{"load5a",   1'b0, 1'b1, 8'h01, 8'h5A, 8'h5A, 8'h00};
    vecs[3]  = '{"loadff",   1'b0, 1'b1, 8'h01, 8'hFF, 8'hFF, 8'h20};
    vecs[4]  = '{"add_carry",1'b0, 1'b1, 8'h02, 8'h01, 8'h00, 8'hC0};
    vecs[5]  = '{"load7f",   1'b0, 1'b1, 8'h01, 8'h7F, 8'h7F, 8'h00};
    vecs[6]  = '{"add_ovf",  1'b0, 1'b1, 8'h02, 8'h01, 8'h80, 8'h30};
    vecs[7]  = '{"load10",   1'b0, 1'b1, 8'h01, 8'h10, 8'h10, 8'h00};
    vecs[8]  = '{"sub_borrow",1'b0,1'b1, 8'h03, 8'h20, 8'hF0, 8'h60};
    vecs[9]  = '{"cmp_eq",   1'b0, 1'b1, 8'h0E, 8'hF0, 8'hF0, 8'h80};
    vecs[10] = '{"load81",   1'b0, 1'b1, 8'h01, 8'h81, 8'h81, 8'h20};
    vecs[11] = '{"shl",      1'b0, 1'b1, 8'h08, 8'h00, 8'h02, 8'h40};
    vecs[12] = '{"ror0",     1'b0, 1'b1, 8'h0B, 8'h00, 8'h01, 8'h00};
    vecs[13] = '{"ror1",     1'b0, 1'b1, 8'h0B, 8'h00, 8'h80, 8'h60};
    vecs[14] = '{"load_hi",  1'b0, 1'b1, 8'hA1, 8'hC3, 8'hC3, 8'h20};
    vecs[15] = '{"and",      1'b0, 1'b1, 8'h04, 8'h0F, 8'h03, 8'h00};
    vecs[16] = '{"or",       1'b0, 1'b1, 8'h05, 8'h80, 8'h83, 8'h20};
    vecs[17] = '{"xor",      1'b0, 1'b1, 8'h06, 8'h83, 8'h00, 8'h80};
    vecs[18] = '{"not",      1'b0, 1'b1, 8'h07, 8'h00, 8'hFF, 8'h20};
    vecs[19] = '{"shr",      1'b0, 1'b1, 8'h09, 8'h00, 8'h7F, 8'h40};
    vecs[20] = '{"inc_ovf",  1'b0, 1'b1, 8'h0C, 8'h00, 8'h80, 8'h30};
    vecs[21] = '{"dec_ovf",  1'b0, 1'b1, 8'h0D, 8'h00, 8'h7F, 8'h10};
    vecs[22] = '{"rol",      1'b0, 1'b1, 8'h0A, 8'h00, 8'hFE, 8'h20};
    vecs[23] = '{"clr",      1'b0, 1'b1, 8'h0F, 8'h55, 8'h00, 8'h80};
    vecs[24] = '{"dec_borrow",1'b0,1'b1, 8'h0D, 8'h00, 8'hFF, 8'h60};
    vecs[25] = '{"sub_7f",   1'b0, 1'b1, 8'h03, 8'h7F, 8'h80, 8'h20};
    vecs[26] = '{"sub_ovf",  1'b0, 1'b1, 8'h53, 8'h01, 8'h7F, 8'h10};

    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ena, vecs[i].uio, vecs[i].b);
      checkOutput(vecs[i].name, vecs[i].exp_acc, vecs[i].exp_uio);
    end

    // NOP with high opcode bits set keeps ACC and the V flag from sub_ovf
    applyStimulus(1'b0, 1'b1, 8'hF0, 8'hAA);
    checkOutput("nop_hold", 8'h7F, 8'h10);

    // Enable low freezes state even with ADD presented every cycle
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h33);
    checkOutput("load33", 8'h33, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h02, 8'h01);
      checkOutput($sformatf("ena_hold%0d", i), 8'h33, 8'h00);
    end
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h01);
    checkOutput("resume_nop", 8'h33, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h01);
    checkOutput("resume_add", 8'h34, 8'h00);

    // Reset on the wrapping INC edge discards the operation
    applyStimulus(1'b0, 1'b1, 8'h01, 8'hFE);
    checkOutput("loadfe", 8'hFE, 8'h20);
    applyStimulus(1'b0, 1'b1, 8'h0C, 8'h00);
    checkOutput("inc_ff", 8'hFF, 8'h20);
    applyStimulus(1'b1, 1'b1, 8'h0C, 8'h00);
    checkOutput("rst_on_wrap", 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h0C, 8'h00);
    checkOutput("inc_after_rst", 8'h01, 8'h00);

    // Reset acts even while enable is low
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h9C);
    checkOutput("load9c", 8'h9C, 8'h20);
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h9C);
    checkOutput("rst_ena0", 8'h00, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
